// File: rtl/arith_pkg.sv
// Shared state encoding and default widths for the sequential divider.
// Ports: none (package only).
package arith_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_M = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle of the sequential divider.
// Ports: start/dividend/divisor from master; ready/busy/done/dz/quotient/remainder from slave.
interface seq_div_if #(
  parameter int N = arith_pkg::DEF_N,
  parameter int M = arith_pkg::DEF_M
);

  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic         dz;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, dz,
    input  quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, dz,
    output quotient, remainder
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: compare partial against divisor, subtract if it fits.
// Ports: partial (M+1) / divisor (M) in; next_partial (M) / q_bit out.
module div_step #(
  parameter int M = arith_pkg::DEF_M
) (
  input  logic [M:0]   partial,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] next_partial,
  output logic         q_bit
);

  logic [M:0] dvs_ext;

  assign dvs_ext = {1'b0, divisor};
  assign q_bit   = (partial >= dvs_ext);

  // Result is always < divisor, so it fits in M bits.
  always_comb begin
    if (q_bit) begin
      next_partial = M'(partial - dvs_ext);
    end else begin
      next_partial = partial[M-1:0];
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: N-bit dividend by M-bit divisor, one bit per cycle.
// Ports: clk, rst (async, active high), bus (seq_div_if.slave).
module seq_div
  import arith_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic      clk,
  input  logic      rst,
  seq_div_if.slave  bus
);

  localparam int CNT_W = $clog2(N + 1);

  div_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0] dvd_q, dvd_d;
  logic [M-1:0] dvs_q, dvs_d;
  logic [M-1:0] part_q, part_d;
  logic [N-1:0] quo_q, quo_d;
  logic [M-1:0] rem_q, rem_d;
  logic         dz_q, dz_d;

  logic [M-1:0] step_rem;
  logic         q_bit;

  // dvd_q shifts left each step; freed LSBs collect quotient bits.
  div_step #(.M(M)) u_step (
    .partial      ({part_q, dvd_q[N-1]}),
    .divisor      (dvs_q),
    .next_partial (step_rem),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = '0;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
            dvd_d   = bus.dividend;
            dvs_d   = bus.divisor;
            part_d  = '0;
            cnt_d   = CNT_W'(N);
          end
        end
      end
      CALC: begin
        dvd_d  = {dvd_q[N-2:0], q_bit};
        part_d = step_rem;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          quo_d   = {dvd_q[N-2:0], q_bit};
          rem_d   = step_rem;
          dz_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.busy      = (state_q == CALC);
  assign bus.done      = (state_q == DONE);
  assign bus.dz        = dz_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule
